// File: rtl/mem_access_stage.sv
// Memory stage between EX/MEM and MEM/WB: issues load/store over a req/ack port and stalls upstream while an access is pending.
// Optional access timeout is built when MEM_TIMEOUT_EN is defined; the default build waits for memAck indefinitely.
module mem_access_stage #(
  parameter logic [31:0] RESET_VALUE    = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inRegWrEn,
  input  logic [1:0]  inMulSel,
  input  logic [31:0] inAluOut,
  input  logic [31:0] inData2Out,
  input  logic [31:0] inPC,
  input  logic [3:0]  inInstType,
  input  logic        inBrTaken,
  input  logic        inIsLoad,
  input  logic        inIsStore,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWrData,
  input  logic        memAck,
  input  logic [31:0] memRdData,
  output logic        memStall,
  output logic        memErr,
  output logic        outRegWrEn,
  output logic [1:0]  outMulSel,
  output logic [31:0] outWbData,
  output logic [31:0] outPC,
  output logic [3:0]  outInstType,
  output logic        outBrTaken,
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state, state_next;
  logic        acc;
  logic        start;
  logic        timeout;
  logic        load_wb;
  logic        load_bubble;
  logic [31:0] wb_data;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // Counts ACCESS cycles that ended without an ack.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !memAck) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`endif

  // Handshake: upstream holds EX/MEM while memStall is high; memReq stays high with
  // address/data/we stable until the single-cycle memAck (or a timeout) closes the access.
  always_comb begin
    acc         = inIsLoad | inIsStore;
    state_next  = state;
    start       = 1'b0;
    load_wb     = 1'b0;
    load_bubble = 1'b0;
`ifdef MEM_TIMEOUT_EN
    timeout = (state == ACCESS) && !memAck && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    timeout = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (acc) begin
          start       = 1'b1;
          load_bubble = 1'b1;
          state_next  = ACCESS;
        end else begin
          load_wb = 1'b1;
        end
      end
      ACCESS: begin
        if (memAck) begin
          load_wb    = 1'b1;
          state_next = IDLE;
        end else begin
          load_bubble = 1'b1;
          if (timeout) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    memStall = ((state == IDLE) && acc) || ((state == ACCESS) && !memAck && !timeout);
    // Stores (including load+store) write back the address, loads the returned word.
    wb_data  = ((state == ACCESS) && !memWe) ? memRdData : inAluOut;
  end

  assign dbg_state = (state == ACCESS);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      memReq      <= 1'b0;
      memWe       <= 1'b0;
      memErr      <= 1'b0;
      memAddr     <= RESET_VALUE;
      memWrData   <= RESET_VALUE;
      outRegWrEn  <= RESET_VALUE[0];
      outMulSel   <= RESET_VALUE[1:0];
      outWbData   <= RESET_VALUE;
      outPC       <= RESET_VALUE;
      outInstType <= RESET_VALUE[3:0];
      outBrTaken  <= RESET_VALUE[0];
    end else begin
      state  <= state_next;
      memErr <= timeout;
      if (start) begin
        memReq    <= 1'b1;
        memWe     <= inIsStore;
        memAddr   <= {inAluOut[31:2], 2'b00};
        memWrData <= inData2Out;
      end else if (state == ACCESS && state_next == IDLE) begin
        memReq <= 1'b0;
      end
      if (load_wb) begin
        outRegWrEn  <= inRegWrEn;
        outMulSel   <= inMulSel;
        outWbData   <= wb_data;
        outPC       <= inPC;
        outInstType <= inInstType;
        outBrTaken  <= inBrTaken;
      end else if (load_bubble) begin
        outRegWrEn  <= 1'b0;
        outInstType <= 4'h0;
        outBrTaken  <= 1'b0;
      end
    end
  end

endmodule
